// File: rtl/uart_tx_arbiter_pkg.sv
// ============================================================================
// uart_tx_arbiter_pkg : shared state encodings and TX FIFO geometry
// Revision 1.0
// ============================================================================
`default_nettype none

package uart_tx_arbiter_pkg;

   localparam int UART_FIFO_DEPTH     = 16;
   localparam int UART_FIFO_COUNTER_W = 5;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_XFER    = 2'd1,
      S_RELEASE = 2'd2
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rr_picker.sv
// ============================================================================
// uart_rr_picker : round-robin pick of the first eligible index after rr_ptr
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_rr_picker #(
   parameter int N_REQ   = 4,
   parameter int GRANT_W = 2
) (
   input  logic [N_REQ-1:0]   eligible,
   input  logic [GRANT_W-1:0] rr_ptr,
   output logic [GRANT_W-1:0] pick_idx,
   output logic               pick_any
);

   logic [GRANT_W-1:0] cand;

   // Scan from farthest to nearest so the nearest eligible index after rr_ptr wins.
   always_comb begin
      pick_idx = '0;
      cand     = '0;
      pick_any = |eligible;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = GRANT_W'((int'(rr_ptr) + k) % N_REQ);
         if (eligible[cand]) begin
            pick_idx = cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : packet-granular round-robin sharing of one UART TX FIFO
// Optional idle watchdog: `define UART_TX_ARB_WATCHDOG_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int GRANT_W    = 2,
   parameter int FIFO_DEPTH = UART_FIFO_DEPTH,
   parameter int TIMEOUT    = 255
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_REQ-1:0]               port_en,
   input  logic [N_REQ-1:0]               req_valid,
   input  logic [8*N_REQ-1:0]             req_data,
   input  logic [N_REQ-1:0]               req_last,
   output logic [N_REQ-1:0]               req_ready,
   output logic                           tf_push,
   output logic [7:0]                     tf_dat,
   input  logic [UART_FIFO_COUNTER_W-1:0] tf_count,
   output logic                           tx_busy,
   output logic [GRANT_W-1:0]             grant_id,
   output logic                           abort_pulse
);

   localparam int c_FILL_W = UART_FIFO_COUNTER_W + 1;

   if (GRANT_W != $clog2(N_REQ) || N_REQ < 2 || N_REQ > 8 ||
       TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
      $error("uart_tx_arbiter: illegal parameter combination");
   end

   arb_state_t         state_q, state_d;
   logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [GRANT_W-1:0] grant_id_q, grant_id_d;
   logic               tx_busy_q, tx_busy_d;
   logic               tf_push_q, tf_push_d;
   logic [7:0]         tf_dat_q, tf_dat_d;

   logic [N_REQ-1:0]    eligible;
   logic [GRANT_W-1:0]  pick_idx;
   logic                pick_any;
   logic [c_FILL_W-1:0] fill_level;
   logic                space_ok;
   logic                g_valid;
   logic                g_last;
   logic [7:0]          g_data;
   logic                accept;

   assign eligible = req_valid & port_en;

   uart_rr_picker #(
      .N_REQ   (N_REQ),
      .GRANT_W (GRANT_W)
   ) u_picker (
      .eligible (eligible),
      .rr_ptr   (rr_ptr_q),
      .pick_idx (pick_idx),
      .pick_any (pick_any)
   );

   // The registered push is a byte not yet reflected in tf_count.
   assign fill_level = {1'b0, tf_count} + c_FILL_W'(tf_push_q);
   assign space_ok   = fill_level < c_FILL_W'(FIFO_DEPTH);

   assign g_valid = req_valid[grant_id_q];
   assign g_last  = req_last[grant_id_q];
   assign g_data  = req_data[{grant_id_q, 3'b000} +: 8];
   assign accept  = (state_q == S_XFER) && g_valid && space_ok;

   always_comb begin
      req_ready = '0;
      if (state_q == S_XFER && space_ok) begin
         req_ready[grant_id_q] = 1'b1;
      end
   end

`ifdef UART_TX_ARB_WATCHDOG_EN
   logic [7:0] idle_cnt_q, idle_cnt_d;
   logic       abort_q, abort_d;
   assign abort_pulse = abort_q;
`else
   assign abort_pulse = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      tx_busy_d  = tx_busy_q;
      tf_push_d  = accept;
      tf_dat_d   = accept ? g_data : tf_dat_q;
`ifdef UART_TX_ARB_WATCHDOG_EN
      idle_cnt_d = idle_cnt_q;
      abort_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
`ifdef UART_TX_ARB_WATCHDOG_EN
            idle_cnt_d = '0;
`endif
            if (pick_any) begin
               grant_id_d = pick_idx;
               tx_busy_d  = 1'b1;
               state_d    = S_XFER;
            end
         end
         S_XFER: begin
            if (accept && g_last) begin
               state_d = S_RELEASE;
            end
`ifdef UART_TX_ARB_WATCHDOG_EN
            // Only an absent requester counts as idle; FIFO back-pressure does not.
            if (accept) begin
               idle_cnt_d = '0;
            end else if (!g_valid) begin
               if (idle_cnt_q == 8'(TIMEOUT - 1)) begin
                  idle_cnt_d = '0;
                  abort_d    = 1'b1;
                  state_d    = S_RELEASE;
               end else begin
                  idle_cnt_d = idle_cnt_q + 8'd1;
               end
            end
`endif
         end
         S_RELEASE: begin
            rr_ptr_d  = grant_id_q;
            tx_busy_d = 1'b0;
            state_d   = S_IDLE;
         end
         default: begin
            tx_busy_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= GRANT_W'(N_REQ - 1);
         grant_id_q <= '0;
         tx_busy_q  <= 1'b0;
         tf_push_q  <= 1'b0;
         tf_dat_q   <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         tx_busy_q  <= tx_busy_d;
         tf_push_q  <= tf_push_d;
         tf_dat_q   <= tf_dat_d;
      end
   end

`ifdef UART_TX_ARB_WATCHDOG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt_q <= '0;
         abort_q    <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         abort_q    <= abort_d;
      end
   end
`endif

   assign tf_push  = tf_push_q;
   assign tf_dat   = tf_dat_q;
   assign tx_busy  = tx_busy_q;
   assign grant_id = grant_id_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// tb_uart_tx_arbiter : directed vector table plus hand-written corner sequences
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  port_en;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        tf_push;
   logic [7:0]  tf_dat;
   logic [4:0]  tf_count;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        abort_pulse;

   int n_checks = 0;
   int n_errors = 0;

   uart_tx_arbiter #(
      .N_REQ      (4),
      .GRANT_W    (2),
      .FIFO_DEPTH (16),
      .TIMEOUT    (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .port_en     (port_en),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tf_push     (tf_push),
      .tf_dat      (tf_dat),
      .tf_count    (tf_count),
      .tx_busy     (tx_busy),
      .grant_id    (grant_id),
      .abort_pulse (abort_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  en;
      logic [3:0]  valid;
      logic [3:0]  last;
      logic [4:0]  cnt;
      logic [31:0] data;
      logic [3:0]  exp_ready;
      logic        exp_push;
      logic [7:0]  exp_dat;
      logic        exp_busy;
      logic [1:0]  exp_gid;
   } vec_t;

   vec_t vq[$];

   localparam logic [31:0] D = 32'h44332211;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [3:0] en, input logic [3:0] valid,
                               input logic [3:0] last, input logic [4:0] cnt,
                               input logic [31:0] data, input logic [3:0] rdy,
                               input logic push, input logic [7:0] dat,
                               input logic busy, input logic [1:0] gid);
      vec_t v;
      v.en = en; v.valid = valid; v.last = last; v.cnt = cnt; v.data = data;
      v.exp_ready = rdy; v.exp_push = push; v.exp_dat = dat;
      v.exp_busy = busy; v.exp_gid = gid;
      vq.push_back(v);
   endfunction

   // Called 1 time unit after a rising edge: drive, check ready, clock, check registers.
   task automatic run_vec(input vec_t v, input int idx);
      port_en   = v.en;
      req_valid = v.valid;
      req_last  = v.last;
      tf_count  = v.cnt;
      req_data  = v.data;
      #1;
      chk($sformatf("v%0d ready", idx), 32'(req_ready), 32'(v.exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d push", idx), 32'(tf_push), 32'(v.exp_push));
      chk($sformatf("v%0d dat", idx), 32'(tf_dat), 32'(v.exp_dat));
      chk($sformatf("v%0d busy", idx), 32'(tx_busy), 32'(v.exp_busy));
      chk($sformatf("v%0d gid", idx), 32'(grant_id), 32'(v.exp_gid));
   endtask

   initial begin
      bit seen_abort;

      // Four single-byte packets, one per requester, in round-robin order
      for (int r = 0; r < 4; r++) begin
         add(4'hF, 4'hF, 4'hF, 5'd0, D, 4'h0, 1'b0, (r == 0) ? 8'h00 : D[8*(r-1) +: 8], 1'b1, 2'(r));
         add(4'hF, 4'hF, 4'hF, 5'd0, D, 4'(1 << r), 1'b1, D[8*r +: 8], 1'b1, 2'(r));
         add(4'hF, 4'hF, 4'hF, 5'd0, D, 4'h0, 1'b0, D[8*r +: 8], 1'b0, 2'(r));
      end
      // Req0 three-byte packet holds the grant against a waiting req2
      add(4'hF, 4'b0101, 4'b0100, 5'd0, 32'h443322A1, 4'h0, 1'b0, 8'h44, 1'b1, 2'd0);
      add(4'hF, 4'b0101, 4'b0100, 5'd0, 32'h443322A1, 4'h1, 1'b1, 8'hA1, 1'b1, 2'd0);
      add(4'hF, 4'b0101, 4'b0100, 5'd0, 32'h443322A2, 4'h1, 1'b1, 8'hA2, 1'b1, 2'd0);
      add(4'hF, 4'b0101, 4'b0101, 5'd0, 32'h443322A3, 4'h1, 1'b1, 8'hA3, 1'b1, 2'd0);
      add(4'hF, 4'b0101, 4'b0101, 5'd0, D, 4'h0, 1'b0, 8'hA3, 1'b0, 2'd0);
      add(4'hF, 4'b0101, 4'b0101, 5'd0, D, 4'h0, 1'b0, 8'hA3, 1'b1, 2'd2);
      add(4'hF, 4'b0101, 4'b0101, 5'd0, D, 4'h4, 1'b1, 8'h33, 1'b1, 2'd2);
      add(4'hF, 4'b0101, 4'b0101, 5'd0, D, 4'h0, 1'b0, 8'h33, 1'b0, 2'd2);
      // FIFO throttling around count + in-flight push = 16
      add(4'hF, 4'b1000, 4'h0, 5'd15, 32'hB1332211, 4'h0, 1'b0, 8'h33, 1'b1, 2'd3);
      add(4'hF, 4'b1000, 4'h0, 5'd15, 32'hB1332211, 4'h8, 1'b1, 8'hB1, 1'b1, 2'd3);
      add(4'hF, 4'b1000, 4'h0, 5'd15, 32'hB2332211, 4'h0, 1'b0, 8'hB1, 1'b1, 2'd3);
      add(4'hF, 4'b1000, 4'h0, 5'd16, 32'hB2332211, 4'h0, 1'b0, 8'hB1, 1'b1, 2'd3);
      add(4'hF, 4'b1000, 4'h0, 5'd14, 32'hB2332211, 4'h8, 1'b1, 8'hB2, 1'b1, 2'd3);
      add(4'hF, 4'b1000, 4'h8, 5'd15, 32'hB3332211, 4'h0, 1'b0, 8'hB2, 1'b1, 2'd3);
      add(4'hF, 4'b1000, 4'h8, 5'd15, 32'hB3332211, 4'h8, 1'b1, 8'hB3, 1'b1, 2'd3);
      add(4'hF, 4'b1000, 4'h8, 5'd15, 32'hB3332211, 4'h0, 1'b0, 8'hB3, 1'b0, 2'd3);
      // Enable mask 0101, then port_en[0] cleared inside req0's packet
      add(4'b0101, 4'hF, 4'hF, 5'd0, D, 4'h0, 1'b0, 8'hB3, 1'b1, 2'd0);
      add(4'b0101, 4'hF, 4'hF, 5'd0, D, 4'h1, 1'b1, 8'h11, 1'b1, 2'd0);
      add(4'b0101, 4'hF, 4'hF, 5'd0, D, 4'h0, 1'b0, 8'h11, 1'b0, 2'd0);
      add(4'b0101, 4'hF, 4'hF, 5'd0, D, 4'h0, 1'b0, 8'h11, 1'b1, 2'd2);
      add(4'b0101, 4'hF, 4'hF, 5'd0, D, 4'h4, 1'b1, 8'h33, 1'b1, 2'd2);
      add(4'b0101, 4'hF, 4'hF, 5'd0, D, 4'h0, 1'b0, 8'h33, 1'b0, 2'd2);
      add(4'b0101, 4'hF, 4'hE, 5'd0, D, 4'h0, 1'b0, 8'h33, 1'b1, 2'd0);
      add(4'b0100, 4'hF, 4'hE, 5'd0, D, 4'h1, 1'b1, 8'h11, 1'b1, 2'd0);
      add(4'b0100, 4'hF, 4'hF, 5'd0, 32'h44332255, 4'h1, 1'b1, 8'h55, 1'b1, 2'd0);
      add(4'b0100, 4'hF, 4'hF, 5'd0, D, 4'h0, 1'b0, 8'h55, 1'b0, 2'd0);
      add(4'b0100, 4'hF, 4'hF, 5'd0, D, 4'h0, 1'b0, 8'h55, 1'b1, 2'd2);
      add(4'b0100, 4'hF, 4'hF, 5'd0, D, 4'h4, 1'b1, 8'h33, 1'b1, 2'd2);
      add(4'b0100, 4'hF, 4'hF, 5'd0, D, 4'h0, 1'b0, 8'h33, 1'b0, 2'd2);

      // Reset state
      rst = 1'b1; port_en = 4'hF; req_valid = 4'hF; req_last = 4'hF;
      req_data = D; tf_count = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst push", 32'(tf_push), 32'd0);
      chk("rst dat", 32'(tf_dat), 32'd0);
      chk("rst ready", 32'(req_ready), 32'd0);
      chk("rst busy", 32'(tx_busy), 32'd0);
      chk("rst gid", 32'(grant_id), 32'd0);
      chk("rst abort", 32'(abort_pulse), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         run_vec(vq[i], i);
      end

      // Asynchronous reset in the middle of a req1 packet
      port_en = 4'hF; req_valid = 4'b0010; req_last = 4'h0; req_data = D; tf_count = 5'd0;
      @(posedge clk); #1;
      chk("mid gid", 32'(grant_id), 32'd1);
      @(posedge clk); #1;
      chk("mid push", 32'(tf_push), 32'd1);
      chk("mid dat", 32'(tf_dat), 32'h22);
      #2 rst = 1'b1;
      #1;
      chk("arst push", 32'(tf_push), 32'd0);
      chk("arst busy", 32'(tx_busy), 32'd0);
      chk("arst ready", 32'(req_ready), 32'd0);
      chk("arst gid", 32'(grant_id), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 4'hF; req_last = 4'hF;
      @(posedge clk); #1;
      chk("post-rst gid", 32'(grant_id), 32'd0);
      chk("post-rst busy", 32'(tx_busy), 32'd1);

      // Granted requester goes silent for the watchdog interval
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 4'b0010; req_last = 4'hF; tf_count = 5'd0;
      @(posedge clk); #1;
      chk("wd gid", 32'(grant_id), 32'd1);
      req_valid = 4'b0100;
      seen_abort = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         seen_abort |= abort_pulse;
      end
      chk("wd early abort", 32'(seen_abort), 32'd0);
      @(posedge clk); #1;
`ifdef UART_TX_ARB_WATCHDOG_EN
      chk("wd abort", 32'(abort_pulse), 32'd1);
      @(posedge clk); #1;
      chk("wd abort width", 32'(abort_pulse), 32'd0);
      chk("wd release busy", 32'(tx_busy), 32'd0);
      @(posedge clk); #1;
      chk("wd next gid", 32'(grant_id), 32'd2);
      chk("wd next busy", 32'(tx_busy), 32'd1);
      // FIFO full with the requester still valid must not time out
      tf_count = 5'd16;
      seen_abort = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         seen_abort |= abort_pulse;
      end
      chk("wd full abort", 32'(seen_abort), 32'd0);
      chk("wd full busy", 32'(tx_busy), 32'd1);
      chk("wd full gid", 32'(grant_id), 32'd2);
`else
      chk("no-wd abort", 32'(abort_pulse), 32'd0);
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         seen_abort |= abort_pulse;
      end
      chk("no-wd never abort", 32'(seen_abort), 32'd0);
      chk("no-wd held busy", 32'(tx_busy), 32'd1);
      chk("no-wd held gid", 32'(grant_id), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_transmitter TX FIFO among N_REQ byte-stream requesters, such as per-core mailboxes in the core switch. It grants one requester at a time, holds the grant for a whole packet (up to and including the byte flagged last), and arbitrates round-robin between packets. It drives the transmitter's tf_push/dat_i and throttles on tf_count so the 16-entry FIFO never overflows.

Parameters:
N_REQ, 4, number of requesters (2..8)
GRANT_W, 2, width of grant index; must equal clog2(N_REQ)
FIFO_DEPTH, 16, TX FIFO capacity in bytes; matches `UART_FIFO_DEPTH`
TIMEOUT, 255, idle-cycle limit for the optional watchdog (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
port_en  in  N_REQ  per-requester enable mask; cleared bit = never granted
req_valid  in  N_REQ  requester i presents a byte
req_data  in  8*N_REQ  byte of requester i at bits [8i+7:8i]
req_last  in  N_REQ  byte is the final byte of the packet
req_ready  out  N_REQ  byte of granted requester accepted this cycle
tf_push  out  1  registered push strobe to transmitter FIFO
tf_dat  out  8  registered data to transmitter dat_i
tf_count  in  `UART_FIFO_COUNTER_W (5)  transmitter FIFO fill level
tx_busy  out  1  a grant is held
grant_id  out  GRANT_W  index of current or most recent grant
abort_pulse  out  1  one-cycle pulse on watchdog release (always 0 without the option)

Behaviour:
- Reset (async, rst=1): state=S_IDLE; rr_ptr=N_REQ-1; tf_push=0; tf_dat=0; req_ready=0; tx_busy=0; grant_id=0; abort_pulse=0. A reset mid-packet drops the rest of the packet. Bytes already in the FIFO are unaffected.
- Space rule: space_ok = (tf_count + tf_push) < FIFO_DEPTH. The registered tf_push counts as one byte in flight. Pops only lower tf_count, so simultaneous pops are safe.
- S_IDLE: eligible = req_valid & port_en. If eligible is nonzero, pick the first set bit scanning rr_ptr+1, rr_ptr+2, … modulo N_REQ. Then latch grant_id, set tx_busy=1, go to S_XFER. The grant is decided one cycle before the first byte can be accepted.
- S_XFER: req_ready[grant_id] = space_ok (combinational); all other ready bits are 0. When req_valid & req_ready:
  - next edge: tf_dat<=byte and tf_push<=1;
  - otherwise tf_push<=0.
  - If req_last on the accepted byte: go to S_RELEASE.
- Clearing port_en mid-packet does not abort; the packet completes.
- S_RELEASE (1 cycle): rr_ptr<=grant_id, tx_busy<=0, go to S_IDLE. Minimum inter-packet gap is 2 cycles (RELEASE + IDLE).
- Throughput: 1 byte/cycle while space_ok. Latency from accept to tf_push is 1 cycle.
- tf_push is asserted at most once per cycle and never when the FIFO would exceed FIFO_DEPTH.
- Single-byte packet (valid & last on the first byte) is legal.
- Undefined state: return to S_IDLE.

Optional Feature:
UART_TX_ARB_WATCHDOG_EN
- Defined: an 8-bit idle counter runs in S_XFER. It clears on every accepted byte and increments while the granted req_valid=0. When it reaches TIMEOUT:
  - abort_pulse=1 for one cycle;
  - go to S_RELEASE (rr_ptr advances past the stalled requester).
  - FIFO-full stalls (valid=1, space_ok=0) do not count.
- Undefined: no counter is built, abort_pulse is tied to 0, and the grant is held indefinitely.

Decomposition:
- Shared package / uart_defines.v holds:
  - state encodings S_IDLE=2'd0, S_XFER=2'd1, S_RELEASE=2'd2;
  - `UART_FIFO_DEPTH` (16);
  - `UART_FIFO_COUNTER_W` (5), already shared.
- One sub-module: uart_rr_picker (combinational rotate/priority-encode of eligible from rr_ptr+1, outputs index + any), reused for the RX-side dispatcher.

Test Plan:
- Reset with req_valid=4'b1111, port_en=4'b1111, tf_count=0. Release reset, then: grant_id=0, then 1, 2, 3 on successive single-byte packets; tf_dat matches each requester's byte.
- Req0 sends a 3-byte packet 0xA1,0xA2,0xA3 while req2 is valid throughout: no req2 byte appears until after 0xA3; req2 is granted next.
- tf_count held at 15 with tf_push=0: one byte is accepted. The next cycle req_ready=0 (15+1=16). After tf_count drops to 14 with tf_push=0, acceptance resumes; no push ever occurs when count+push=16.
- port_en=4'b0101 with all four valid: grants alternate only 0, 2. Clearing port_en[0] during req0's packet still completes that packet.
- rst asserted mid-packet, asynchronously between clock edges: tf_push=0, tx_busy=0, req_ready=0 immediately. After release, the arbiter is idle and grants from index 0.
- Watchdog on, TIMEOUT=10, req1 granted and then goes invalid: abort_pulse after 10 idle cycles, req2 granted next. With the FIFO full instead (valid=1), no abort occurs.
